// File: rtl/pci_master_ctrl.sv
// PCI initiator sequencer: REQ/GNT arbitration, address phase, IRDY#/TRDY# data phases, STOP# disconnect.
// Optional master-abort devsel timer is built when MASTER_ABORT_EN is defined.
module pci_master_ctrl #(
  parameter int unsigned DEVSEL_TIMEOUT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_start,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_num,
  input  logic [3:0]  req_be,
  input  logic [31:0] wr_data,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        disc,
  output logic        abort,
  output logic        req_bus,
  input  logic        gnt,
  output logic        frame,
  output logic        irdy,
  input  logic        trdy,
  input  logic        devsel,
  input  logic        stop,
  output logic [3:0]  c_be,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  input  logic [31:0] ad_in
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_DATA, S_DISC, S_MABT, S_REL} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d, num_q, num_d, be_q, be_d, rem_q, rem_d, c_be_q, c_be_d;
  logic [31:0] addr_q, addr_d, ad_out_q, ad_out_d, rd_data_q, rd_data_d;
  logic        frame_q, frame_d, irdy_q, irdy_d, req_bus_q, req_bus_d, ad_oe_q, ad_oe_d;
  logic        busy_q, busy_d, done_q, done_d, disc_q, disc_d;
  logic        wr_pop_q, wr_pop_d, rd_valid_q, rd_valid_d;
  logic        xfer, stop_hit, tmo, enter_rel;
  logic [3:0]  rem_nx;

`ifdef MASTER_ABORT_EN
  localparam logic [3:0] TMO_LAST = 4'(DEVSEL_TIMEOUT - 1);
  logic [3:0] tmr_q, tmr_d;
  logic       dev_seen_q, dev_seen_d, abort_q, abort_d;
`endif

  always_comb begin
    state_d = state_q; cmd_d = cmd_q; num_d = num_q; be_d = be_q; rem_d = rem_q;
    addr_d = addr_q; c_be_d = c_be_q; ad_out_d = ad_out_q; ad_oe_d = ad_oe_q;
    frame_d = frame_q; irdy_d = irdy_q; req_bus_d = req_bus_q; busy_d = busy_q;
    rd_data_d = rd_data_q;
    done_d = 1'b0; disc_d = 1'b0; wr_pop_d = 1'b0; rd_valid_d = 1'b0;
    enter_rel = 1'b0;
    // irdy_q is low for the whole data phase, so a transfer is just TRDY# sampled low
    xfer     = (state_q == S_DATA) && !irdy_q && !trdy;
    stop_hit = (state_q == S_DATA) && !stop && !devsel;
    rem_nx   = rem_q - {3'b000, xfer};
`ifdef MASTER_ABORT_EN
    tmr_d = tmr_q; dev_seen_d = dev_seen_q; abort_d = 1'b0;
    tmo = (state_q == S_DATA) && devsel && !dev_seen_q && (tmr_q == TMO_LAST);
    if (state_q == S_DATA) begin
      if (!devsel) dev_seen_d = 1'b1;
      else if (!dev_seen_q) tmr_d = tmr_q + 4'd1;
    end
`else
    tmo = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (req_start && req_num != 4'd0) begin
        cmd_d = req_cmd; addr_d = req_addr; num_d = req_num; be_d = req_be;
        busy_d = 1'b1; req_bus_d = 1'b0; state_d = S_REQ;
      end
      S_REQ: if (!gnt) begin
        state_d = S_ADDR; frame_d = 1'b0; ad_out_d = addr_q; ad_oe_d = 1'b1;
        c_be_d = cmd_q; req_bus_d = 1'b1;
      end
      S_ADDR: begin
        state_d = S_DATA; irdy_d = 1'b0; c_be_d = be_q; rem_d = num_q;
        frame_d = (num_q == 4'd1);
        ad_oe_d = cmd_q[0];
        ad_out_d = cmd_q[0] ? wr_data : 32'h0;
`ifdef MASTER_ABORT_EN
        tmr_d = 4'd0; dev_seen_d = 1'b0;
`endif
      end
      S_DATA: begin
        if (cmd_q[0]) ad_out_d = wr_data;
        if (xfer) begin
          rem_d = rem_nx;
          wr_pop_d = cmd_q[0];
          rd_valid_d = !cmd_q[0];
          if (!cmd_q[0]) rd_data_d = ad_in;
          if (rem_q == 4'd2) frame_d = 1'b1;
        end
        if (stop_hit) begin
          if (!frame_q) begin
            state_d = S_DISC; frame_d = 1'b1;
          end else begin
            enter_rel = 1'b1; disc_d = (rem_nx != 4'd0);
          end
        end else if (xfer && rem_q == 4'd1) begin
          enter_rel = 1'b1;
        end else if (tmo) begin
          state_d = S_MABT; frame_d = 1'b1;
        end
      end
      S_DISC: begin
        enter_rel = 1'b1; disc_d = (rem_q != 4'd0);
      end
      S_MABT: begin
        enter_rel = 1'b1;
`ifdef MASTER_ABORT_EN
        abort_d = 1'b1;
`endif
      end
      S_REL: begin
        state_d = S_IDLE; busy_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_rel) begin
      state_d = S_REL; frame_d = 1'b1; irdy_d = 1'b1; ad_oe_d = 1'b0;
      ad_out_d = 32'h0; c_be_d = 4'hF; done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; cmd_q <= 4'h0; num_q <= 4'h0; be_q <= 4'h0; rem_q <= 4'h0;
      addr_q <= 32'h0; c_be_q <= 4'hF; ad_out_q <= 32'h0; ad_oe_q <= 1'b0;
      frame_q <= 1'b1; irdy_q <= 1'b1; req_bus_q <= 1'b1; busy_q <= 1'b0;
      done_q <= 1'b0; disc_q <= 1'b0; wr_pop_q <= 1'b0; rd_valid_q <= 1'b0;
      rd_data_q <= 32'h0;
`ifdef MASTER_ABORT_EN
      tmr_q <= 4'd0; dev_seen_q <= 1'b0; abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d; cmd_q <= cmd_d; num_q <= num_d; be_q <= be_d; rem_q <= rem_d;
      addr_q <= addr_d; c_be_q <= c_be_d; ad_out_q <= ad_out_d; ad_oe_q <= ad_oe_d;
      frame_q <= frame_d; irdy_q <= irdy_d; req_bus_q <= req_bus_d; busy_q <= busy_d;
      done_q <= done_d; disc_q <= disc_d; wr_pop_q <= wr_pop_d; rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
`ifdef MASTER_ABORT_EN
      tmr_q <= tmr_d; dev_seen_q <= dev_seen_d; abort_q <= abort_d;
`endif
    end
  end

  assign wr_pop = wr_pop_q;     assign rd_data = rd_data_q;   assign rd_valid = rd_valid_q;
  assign busy = busy_q;         assign done = done_q;         assign disc = disc_q;
  assign req_bus = req_bus_q;   assign frame = frame_q;       assign irdy = irdy_q;
  assign c_be = c_be_q;         assign ad_out = ad_out_q;     assign ad_oe = ad_oe_q;
`ifdef MASTER_ABORT_EN
  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_pci_master_ctrl.sv
// Directed bench for pci_master_ctrl: a small bus-target responder drives per-data-cycle patterns.
module tb_pci_master_ctrl;
  logic clk, rst, req_start, gnt, trdy, devsel, stop;
  logic [3:0] req_cmd, req_num, req_be;
  logic [31:0] req_addr, wr_data, ad_in;
  logic wr_pop, rd_valid, busy, done, disc, abort, req_bus, frame, irdy, ad_oe;
  logic [31:0] rd_data, ad_out;
  logic [3:0] c_be;
  int errors = 0, checks = 0;

  // burst measurements
  int m_pop, m_rdv, m_dcyc, m_f1, m_rdoe;
  logic m_lastf, m_done, m_disc, m_abort, m_aoe;
  logic [31:0] m_rdata, m_aad;
  logic [3:0] m_acbe;

  pci_master_ctrl #(.DEVSEL_TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_num(req_num), .req_be(req_be), .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .disc(disc), .abort(abort),
    .req_bus(req_bus), .gnt(gnt), .frame(frame), .irdy(irdy), .trdy(trdy), .devsel(devsel),
    .stop(stop), .c_be(c_be), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start_req(input logic [3:0] cmd, input logic [31:0] addr, input logic [3:0] num, input logic [3:0] be);
    req_cmd = cmd; req_addr = addr; req_num = num; req_be = be; req_start = 1'b1;
    tick;
    req_start = 1'b0;
  endtask

  // bit k of each pattern is the active-low target signal during the k-th cycle with IRDY# low
  task automatic run_burst(input int gnt_dly, input logic [31:0] trdy_pat, input logic [31:0] dev_pat,
                           input logic [31:0] stop_pat, input logic [31:0] rdval, input int max_cyc);
    int k, cyc;
    k = 0; cyc = 0;
    m_pop = 0; m_rdv = 0; m_dcyc = 0; m_f1 = 0; m_rdoe = 0;
    m_lastf = 1'b0; m_done = 1'b0; m_disc = 1'b0; m_abort = 1'b0; m_aoe = 1'b0;
    m_rdata = 32'h0; m_aad = 32'h0; m_acbe = 4'h0;
    ad_in = rdval;
    while (!m_done && cyc < max_cyc) begin
      gnt = (cyc >= gnt_dly && req_bus == 1'b0) ? 1'b0 : 1'b1;
      if (irdy == 1'b0 && k < 32) begin
        trdy = trdy_pat[k]; devsel = dev_pat[k]; stop = stop_pat[k];
        wr_data = 32'hA000_0000 + 32'(k); k++;
      end else begin
        trdy = 1'b1; devsel = 1'b1; stop = 1'b1;
      end
      tick; cyc++;
      if (wr_pop) m_pop++;
      if (rd_valid) begin m_rdv++; m_rdata = rd_data; end
      if (frame == 1'b0 && irdy == 1'b1) begin m_aad = ad_out; m_acbe = c_be; m_aoe = ad_oe; end
      if (irdy == 1'b0) begin
        m_dcyc++; m_lastf = frame;
        if (frame) m_f1++;
        if (ad_oe) m_rdoe++;
      end
      if (done) begin m_done = 1'b1; m_disc = disc; m_abort = abort; end
    end
    gnt = 1'b1; trdy = 1'b1; devsel = 1'b1; stop = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick; tick;
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL rst_frame got=%b exp=1", frame); end
    checks++; if (irdy !== 1'b1) begin errors++; $display("FAIL rst_irdy got=%b exp=1", irdy); end
    checks++; if (req_bus !== 1'b1) begin errors++; $display("FAIL rst_req_bus got=%b exp=1", req_bus); end
    checks++; if (c_be !== 4'hF) begin errors++; $display("FAIL rst_c_be got=%h exp=f", c_be); end
    checks++; if (ad_out !== 32'h0 || ad_oe !== 1'b0) begin errors++; $display("FAIL rst_ad got=%h/%b exp=0/0", ad_out, ad_oe); end
    checks++; if ({busy, done, disc, abort, wr_pop, rd_valid} !== 6'b0) begin errors++; $display("FAIL rst_flags got=%b exp=000000", {busy, done, disc, abort, wr_pop, rd_valid}); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd_data got=%h exp=0", rd_data); end
    rst = 1'b0; tick;
  endtask

  task automatic test_ignore_zero;
    start_req(4'b0111, 32'h2000, 4'd0, 4'h0);
    checks++; if (busy !== 1'b0 || req_bus !== 1'b1) begin errors++; $display("FAIL num0_ignored got busy=%b req=%b exp 0/1", busy, req_bus); end
    tick;
  endtask

  task automatic test_write3;
    start_req(4'b0111, 32'h1000, 4'd3, 4'h0);
    checks++; if (busy !== 1'b1 || req_bus !== 1'b0) begin errors++; $display("FAIL wr3_req got busy=%b req=%b exp 1/0", busy, req_bus); end
    run_burst(1, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 60);
    checks++; if (m_aad !== 32'h1000 || m_acbe !== 4'b0111 || m_aoe !== 1'b1) begin errors++; $display("FAIL wr3_addr got=%h/%b/%b exp=1000/0111/1", m_aad, m_acbe, m_aoe); end
    checks++; if (m_pop !== 3) begin errors++; $display("FAIL wr3_pops got=%0d exp=3", m_pop); end
    checks++; if (m_f1 !== 1 || m_lastf !== 1'b1 || m_dcyc !== 4) begin errors++; $display("FAIL wr3_frame got f1=%0d last=%b dcyc=%0d exp 1/1/4", m_f1, m_lastf, m_dcyc); end
    checks++; if (m_done !== 1'b1 || m_disc !== 1'b0 || m_abort !== 1'b0) begin errors++; $display("FAIL wr3_done got=%b disc=%b abort=%b exp 1/0/0", m_done, m_disc, m_abort); end
    checks++; if (frame !== 1'b1 || irdy !== 1'b1 || ad_oe !== 1'b0 || c_be !== 4'hF) begin errors++; $display("FAIL wr3_release got f=%b i=%b oe=%b cbe=%h", frame, irdy, ad_oe, c_be); end
    tick;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL wr3_idle got busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_read1;
    start_req(4'b0110, 32'h3000, 4'd1, 4'h0);
    run_burst(0, 32'hFFFF_FFFB, 32'h0000_0001, 32'hFFFF_FFFF, 32'hDEADBEEF, 60);
    checks++; if (m_f1 !== 3 || m_dcyc !== 3) begin errors++; $display("FAIL rd1_frame got f1=%0d dcyc=%0d exp 3/3", m_f1, m_dcyc); end
    checks++; if (m_rdoe !== 0) begin errors++; $display("FAIL rd1_ad_oe got=%0d exp=0", m_rdoe); end
    checks++; if (m_rdv !== 1 || m_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd1_data got n=%0d d=%h exp 1/deadbeef", m_rdv, m_rdata); end
    checks++; if (m_done !== 1'b1 || m_disc !== 1'b0) begin errors++; $display("FAIL rd1_done got=%b disc=%b exp 1/0", m_done, m_disc); end
    tick;
  endtask

  task automatic test_write_wait;
    start_req(4'b0111, 32'h4000, 4'd4, 4'h3);
    run_burst(0, 32'hFFFF_FFCC, 32'h0, 32'hFFFF_FFFF, 32'h0, 60);
    checks++; if (m_pop !== 4) begin errors++; $display("FAIL wrw_pops got=%0d exp=4", m_pop); end
    checks++; if (m_dcyc !== 6) begin errors++; $display("FAIL wrw_irdy_cycles got=%0d exp=6", m_dcyc); end
    checks++; if (m_f1 !== 1 || m_lastf !== 1'b1) begin errors++; $display("FAIL wrw_frame got f1=%0d last=%b exp 1/1", m_f1, m_lastf); end
    checks++; if (m_done !== 1'b1 || m_disc !== 1'b0) begin errors++; $display("FAIL wrw_done got=%b disc=%b exp 1/0", m_done, m_disc); end
    tick;
  endtask

  task automatic test_disconnect;
    start_req(4'b0110, 32'h5000, 4'd5, 4'h0);
    run_burst(0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFD, 32'h1234_5678, 60);
    checks++; if (m_rdv !== 2 || m_rdata !== 32'h1234_5678) begin errors++; $display("FAIL disc_rdv got n=%0d d=%h exp 2/12345678", m_rdv, m_rdata); end
    checks++; if (m_dcyc !== 3 || m_f1 !== 1 || m_lastf !== 1'b1) begin errors++; $display("FAIL disc_cycle got dcyc=%0d f1=%0d last=%b exp 3/1/1", m_dcyc, m_f1, m_lastf); end
    checks++; if (m_done !== 1'b1 || m_disc !== 1'b1 || m_abort !== 1'b0) begin errors++; $display("FAIL disc_done got=%b disc=%b abort=%b exp 1/1/0", m_done, m_disc, m_abort); end
    tick;
    checks++; if (disc !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL disc_clear got disc=%b busy=%b exp 0/0", disc, busy); end
  endtask

  task automatic test_master_abort;
    start_req(4'b0111, 32'h6000, 4'd2, 4'h0);
`ifdef MASTER_ABORT_EN
    run_burst(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 60);
    checks++; if (m_done !== 1'b1 || m_abort !== 1'b1 || m_disc !== 1'b0) begin errors++; $display("FAIL mabt_done got=%b abort=%b disc=%b exp 1/1/0", m_done, m_abort, m_disc); end
    checks++; if (m_dcyc !== 6 || m_f1 !== 1) begin errors++; $display("FAIL mabt_cycles got dcyc=%0d f1=%0d exp 6/1", m_dcyc, m_f1); end
    checks++; if (m_pop !== 0 || m_rdv !== 0) begin errors++; $display("FAIL mabt_data got pop=%0d rdv=%0d exp 0/0", m_pop, m_rdv); end
    tick;
    checks++; if (abort !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mabt_clear got abort=%b busy=%b exp 0/0", abort, busy); end
`else
    run_burst(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 40);
    checks++; if (m_done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL noabt_wait got done=%b busy=%b exp 0/1", m_done, busy); end
    checks++; if (irdy !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL noabt_irdy got irdy=%b abort=%b exp 0/0", irdy, abort); end
    rst = 1'b1; tick; rst = 1'b0; tick;
`endif
  endtask

  task automatic test_reset_mid_burst;
    int nd;
    start_req(4'b0111, 32'h7000, 4'd4, 4'h0);
    gnt = 1'b0; tick; gnt = 1'b1;          // ADDR
    tick;                                  // DATA cycle 1
    trdy = 1'b0; devsel = 1'b0; tick;      // phase 1 done, now in phase 2
    checks++; if (irdy !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rstm_pre got irdy=%b busy=%b exp 0/1", irdy, busy); end
    rst = 1'b1; tick; rst = 1'b0;
    trdy = 1'b1; devsel = 1'b1;
    checks++; if (frame !== 1'b1 || irdy !== 1'b1 || ad_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstm_state got f=%b i=%b oe=%b busy=%b", frame, irdy, ad_oe, busy); end
    nd = 0;
    for (int i = 0; i < 4; i++) begin tick; if (done) nd++; end
    checks++; if (nd !== 0 || done !== 1'b0) begin errors++; $display("FAIL rstm_no_done got=%0d exp=0", nd); end
    start_req(4'b0111, 32'h8000, 4'd2, 4'h0);
    run_burst(0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 60);
    checks++; if (m_done !== 1'b1 || m_pop !== 2 || m_aad !== 32'h8000) begin errors++; $display("FAIL rstm_after got done=%b pop=%0d addr=%h exp 1/2/8000", m_done, m_pop, m_aad); end
    tick;
  endtask

  initial begin
    rst = 1'b1; req_start = 1'b0; req_cmd = 4'h0; req_addr = 32'h0; req_num = 4'h0; req_be = 4'h0;
    wr_data = 32'h0; ad_in = 32'h0; gnt = 1'b1; trdy = 1'b1; devsel = 1'b1; stop = 1'b1;
    test_reset;
    test_ignore_zero;
    test_write3;
    test_read1;
    test_write_wait;
    test_disconnect;
    test_master_abort;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pci_master_ctrl.md
Name: pci_master_ctrl

Overview:
PCI initiator-side transaction sequencer for the bus interface. It accepts one burst request (command, address, data-phase count, byte enables) and arbitrates for the bus. It then drives the address phase, runs the data phases with the IRDY#/TRDY# handshake, and deasserts FRAME# before the final data phase. It terminates on target disconnect (STOP#) or master abort, and feeds and collects data through the byte-enable datapath.

Parameters:
DEVSEL_TIMEOUT, 5, cycles after the address phase without DEVSEL# before master abort (range 3..15).

Ports:
clk  in  1  bus clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
req_start  in  1  one-cycle request pulse; sampled only in IDLE.
req_cmd  in  4  PCI command (4'b0110 memory read, 4'b0111 memory write); bit0 = 1 means write.
req_addr  in  32  transaction address.
req_num  in  4  number of data phases, 1..15.
req_be  in  4  active-low byte enables, used for every data phase.
wr_data  in  32  write data for the current phase.
wr_pop  out  1  pulses on each completed write data phase.
rd_data  out  32  captured read data.
rd_valid  out  1  pulses on each completed read data phase.
busy  out  1  transaction in progress.
done  out  1  one-cycle completion pulse.
disc  out  1  valid with done: target disconnected before all phases completed.
abort  out  1  valid with done: master abort.
req_bus  out  1  REQ#, active-low.
gnt  in  1  GNT#, active-low.
frame  out  1  FRAME#, active-low.
irdy  out  1  IRDY#, active-low.
trdy  in  1  TRDY#, active-low.
devsel  in  1  DEVSEL#, active-low.
stop  in  1  STOP#, active-low.
c_be  out  4  C/BE#.
ad_out  out  32  AD drive value.
ad_oe  out  1  AD output enable.
ad_in  in  32  AD sampled value.

Behaviour:
- Reset values (next edge with rst=1, from any state, mid-burst included):
  - frame=1, irdy=1, req_bus=1, c_be=4'hF, ad_out=0, ad_oe=0.
  - busy, done, disc, abort, wr_pop, rd_valid all 0; rd_data=0.
  - State IDLE. No done is issued for a transaction aborted by reset.
- All outputs are registered.
- IDLE:
  - req_start=1 and req_num!=0: latch cmd/addr/num/be, set busy=1 and req_bus=0, go to REQ.
  - req_start with req_num=0 is ignored.
  - req_start while busy is ignored.
- REQ: hold until gnt=0, frame_in-idle not checked. Then ADDR.
- ADDR (1 cycle):
  - Drive frame=0, ad_out=addr, ad_oe=1, c_be=cmd, req_bus=1.
  - Load remaining=req_num; clear the devsel timer. Go to DATA.
- DATA:
  - irdy=0, c_be=be.
  - Write: ad_oe=1, ad_out=wr_data.
  - Read: ad_oe=0 from the first DATA cycle (turnaround).
  - Transfer = irdy=0 & trdy=0 sampled at an edge. On a transfer:
    - remaining decrements.
    - write: wr_pop=1 for that cycle.
    - read: rd_data<=ad_in and rd_valid=1 the next cycle.
  - FRAME# deassertion:
    - frame=1 during the final phase.
    - req_num=1: frame=1 from the first DATA cycle.
    - Otherwise frame<=1 on the transfer that leaves remaining=1.
  - Transfer with remaining reaching 0: go to RELEASE.
- STOP# in DATA: stop=0 & devsel=0 sampled.
  - A coincident trdy=0 still counts as a transfer.
  - If frame was 0: go to DISC (frame=1, irdy=0, 1 cycle, no transfer counted), then RELEASE.
  - Otherwise go directly to RELEASE.
  - disc=1 if remaining!=0 after this edge.
- Master abort:
  - Timer counts DATA cycles with devsel=1.
  - Reaching DEVSEL_TIMEOUT: frame=1, irdy=0 for 1 cycle, then RELEASE with abort=1.
  - devsel=0 once freezes the timer for the rest of the burst.
- RELEASE (1 cycle):
  - frame=1, irdy=1, ad_oe=0, c_be=4'hF.
  - done=1; busy=0 next edge; go to IDLE.
  - disc/abort are valid only in this cycle.
- Simultaneous stop and timeout on the same edge: stop wins (devsel=0 is required for stop).
- remaining never underflows; transfers after reaching 0 are impossible by construction.

Optional Feature:
MASTER_ABORT_EN
- Defined: devsel timer and abort path present as above.
- Undefined: no timer; DATA waits indefinitely for devsel/trdy; abort tied to 0.

Test Plan:
1. Write, num=3, addr=32'h1000, gnt=0 at the 2nd cycle, devsel/trdy=0 from the 2nd DATA cycle -> ADDR drives AD=32'h1000 and c_be=4'b0111; 3 wr_pop pulses; frame=1 exactly in the 3rd-phase cycle; done=1, disc=0.
2. Read, num=1, trdy=0 at DATA cycle 3, ad_in=32'hDEADBEEF -> frame=1 throughout DATA; ad_oe=0; rd_valid once with rd_data=32'hDEADBEEF; done next RELEASE.
3. Write, num=4, with trdy=1 for 2 cycles between phases 2 and 3 -> only 4 wr_pop pulses; irdy held 0 through the wait; frame=1 only in the final phase.
4. Read, num=5, stop=0 with trdy=0 on phase 2 -> 2 rd_valid; DISC cycle (frame=1, irdy=0); done=1 with disc=1.
5. devsel held 1 (macro defined, DEVSEL_TIMEOUT=5) -> abort after 5 DATA cycles; done=1, abort=1, no wr_pop/rd_valid. Macro undefined -> busy stays 1.
6. rst=1 mid-burst at phase 2 of 4 -> next edge frame=1, irdy=1, ad_oe=0, busy=0, no done; a new req_start afterwards completes normally.
